// File: rtl/fc_pool_pkg.sv
// Shared types and constant helpers for the pooled FC buffer writer.
package fc_pool_pkg;

  typedef enum logic {
    PoolMax = 1'b0,
    PoolAvg = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StEmit,
    StDone
  } pool_state_e;

  function automatic int unsigned ceil_div(int unsigned a, int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned clog2(int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, v}) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that stays legal when the count is 1.
  function automatic int unsigned cnt_w(int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_pool_lane.sv
// One output column/channel accumulator: folds POOL pixels of a row into a
// running max or sum and presents the pooled result.
module fc_pool_lane
  import fc_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned POOL       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            first,
  input  pool_mode_e                      mode,
  input  logic [POOL-1:0][DATA_WIDTH-1:0] pix,
  output logic [DATA_WIDTH-1:0]           result
);

  localparam int unsigned SH    = 2 * clog2(POOL);
  localparam int unsigned ACC_W = DATA_WIDTH + SH;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] row_max, row_sum, pix_ext;
  logic        [ACC_W-1:0] rnd;
  logic                    unused_rnd_lsb;

  always_comb begin
    pix_ext = '0;
    row_max = {{SH{pix[0][DATA_WIDTH-1]}}, pix[0]};
    row_sum = '0;
    for (int k = 0; k < int'(POOL); k++) begin
      pix_ext = {{SH{pix[k][DATA_WIDTH-1]}}, pix[k]};
      row_sum = row_sum + pix_ext;
      if (pix_ext > row_max) row_max = pix_ext;
    end

    acc_d = acc_q;
    if (load) begin
      if (mode == PoolMax) begin
        // Strict compare: an equal newcomer never replaces the held value.
        acc_d = (first || (row_max > acc_q)) ? row_max : acc_q;
      end else begin
        acc_d = first ? row_sum : acc_q + row_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // Selecting bits above SH is the arithmetic shift; rounds half toward +inf.
  assign rnd            = acc_q + (ACC_W'(1) << (SH - 1));
  assign unused_rnd_lsb = ^rnd[SH-1:0];
  assign result         = (mode == PoolMax) ? acc_q[DATA_WIDTH-1:0] : rnd[SH +: DATA_WIDTH];

endmodule

// File: rtl/fc_pool_writer.sv
// Pools conv output rows (max or rounded average) and writes the pooled pixels
// into a BATCH-banked FC buffer, stalling the input while each row is emitted.
module fc_pool_writer
  import fc_pool_pkg::*;
#(
  parameter int unsigned AF         = 3,
  parameter int unsigned BATCH      = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned C          = 512,
  parameter int unsigned W_IN       = 14,
  parameter int unsigned H_IN       = 14,
  parameter int unsigned POOL       = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        mode,
  output logic                                        busy,
  output logic                                        done,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [W_IN-1:0][AF-1:0][DATA_WIDTH-1:0]     in_data,
  output logic [BATCH-1:0][AF-1:0]                    wr_en,
  output logic [BATCH-1:0][ADDR_WIDTH-1:0]            wr_addr,
  output logic [BATCH-1:0][AF-1:0][DATA_WIDTH-1:0]    wr_data
);

  localparam int unsigned G     = ceil_div(C, AF);
  localparam int unsigned W_OUT = W_IN / POOL;
  localparam int unsigned H_OUT = H_IN / POOL;
  localparam int unsigned BW    = cnt_w(BATCH);
  localparam int unsigned YW    = cnt_w(H_OUT);
  localparam int unsigned GW    = cnt_w(G);
  localparam int unsigned XW    = cnt_w(W_OUT);
  localparam int unsigned RW    = cnt_w(POOL);

  if (!(POOL == 2 || POOL == 4)) begin : g_bad_pool
    $error("fc_pool_writer: POOL must be 2 or 4");
  end
  if (W_IN == 0 || (W_IN % POOL) != 0) begin : g_bad_w
    $error("fc_pool_writer: W_IN must be a non-zero multiple of POOL");
  end
  if (H_IN == 0 || (H_IN % POOL) != 0) begin : g_bad_h
    $error("fc_pool_writer: H_IN must be a non-zero multiple of POOL");
  end
  if (AF == 0 || BATCH == 0 || C == 0 || DATA_WIDTH < 2 || ADDR_WIDTH == 0) begin : g_bad_dim
    $error("fc_pool_writer: AF, BATCH, C, ADDR_WIDTH must be non-zero, DATA_WIDTH >= 2");
  end

  pool_state_e state_q, state_d;
  pool_mode_e  mode_q, mode_d;
  logic [BW-1:0] batch_q, batch_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [GW-1:0] g_q, g_d;
  logic [RW-1:0] r_q, r_d;
  logic [XW-1:0] ox_q, ox_d;

  logic lane_load, lane_first, emit;
  logic [ADDR_WIDTH-1:0] addr;
  logic [W_OUT-1:0][AF-1:0][DATA_WIDTH-1:0] lane_res;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    batch_d    = batch_q;
    oy_d       = oy_q;
    g_d        = g_q;
    r_d        = r_q;
    ox_d       = ox_q;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    lane_load  = 1'b0;
    lane_first = 1'b0;
    emit       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          mode_d  = pool_mode_e'(mode);
          batch_d = '0;
          oy_d    = '0;
          g_d     = '0;
          r_d     = '0;
          ox_d    = '0;
        end
      end
      StAccum: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          lane_load  = 1'b1;
          lane_first = (r_q == '0);
          if (r_q == RW'(POOL - 1)) begin
            r_d     = '0;
            ox_d    = '0;
            state_d = StEmit;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      StEmit: begin
        busy = 1'b1;
        emit = 1'b1;
        if (ox_q == XW'(W_OUT - 1)) begin
          ox_d    = '0;
          state_d = StAccum;
          if (g_q == GW'(G - 1)) begin
            g_d = '0;
            if (oy_q == YW'(H_OUT - 1)) begin
              oy_d = '0;
              if (batch_q == BW'(BATCH - 1)) begin
                batch_d = '0;
                state_d = StDone;
              end else begin
                batch_d = batch_q + 1'b1;
              end
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            g_d = g_q + 1'b1;
          end
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= PoolMax;
      batch_q <= '0;
      oy_q    <= '0;
      g_q     <= '0;
      r_q     <= '0;
      ox_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      batch_q <= batch_d;
      oy_q    <= oy_d;
      g_q     <= g_d;
      r_q     <= r_d;
      ox_q    <= ox_d;
    end
  end

  assign addr = ((ADDR_WIDTH'(oy_q) * ADDR_WIDTH'(G)) + ADDR_WIDTH'(g_q)) * ADDR_WIDTH'(W_OUT)
              + ADDR_WIDTH'(ox_q);

  // Only the bank of the current batch image sees the write; the rest stay 0.
  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    if (emit) begin
      for (int b = 0; b < int'(BATCH); b++) begin
        if (batch_q == BW'(b)) begin
          wr_en[b]   = '1;
          wr_addr[b] = addr;
          wr_data[b] = lane_res[ox_q];
        end
      end
    end
  end

  for (genvar ox = 0; ox < int'(W_OUT); ox++) begin : g_col
    for (genvar a = 0; a < int'(AF); a++) begin : g_ch
      logic [POOL-1:0][DATA_WIDTH-1:0] pix;
      for (genvar k = 0; k < int'(POOL); k++) begin : g_pix
        assign pix[k] = in_data[ox*POOL+k][a];
      end
      fc_pool_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .POOL      (POOL)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .load  (lane_load),
        .first (lane_first),
        .mode  (mode_q),
        .pix   (pix),
        .result(lane_res[ox][a])
      );
    end
  end

endmodule

// File: tb/tb_fc_pool_writer.sv
// Directed bench: max/avg pooling, signed edges, back-pressure, mid-job reset
// and a POOL=4 instance.
module tb_fc_pool_writer;

  localparam int unsigned AF = 2, BATCH = 2, DW = 8, C = 4, W = 4, H = 4, P = 2, AW = 32;
  localparam int unsigned W4 = 8, H4 = 8, P4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, in_valid, busy, done, in_ready;
  logic [W-1:0][AF-1:0][DW-1:0]    in_data;
  logic [BATCH-1:0][AF-1:0]        wr_en;
  logic [BATCH-1:0][AW-1:0]        wr_addr;
  logic [BATCH-1:0][AF-1:0][DW-1:0] wr_data;

  logic start4, mode4, in_valid4, busy4, done4, in_ready4;
  logic [W4-1:0][AF-1:0][DW-1:0]   in_data4;
  logic [BATCH-1:0][AF-1:0]        wr_en4;
  logic [BATCH-1:0][AW-1:0]        wr_addr4;
  logic [BATCH-1:0][AF-1:0][DW-1:0] wr_data4;

  fc_pool_writer #(
    .AF(AF), .BATCH(BATCH), .DATA_WIDTH(DW), .C(C), .W_IN(W), .H_IN(H), .POOL(P), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  fc_pool_writer #(
    .AF(AF), .BATCH(BATCH), .DATA_WIDTH(DW), .C(C), .W_IN(W4), .H_IN(H4), .POOL(P4),
    .ADDR_WIDTH(AW)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .busy(busy4), .done(done4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cap_bank[$], cap_addr[$], cap_d0[$], cap_d1[$], cap_cyc[$], done_cyc[$];
  int cap4_bank[$], cap4_addr[$], cap4_d0[$], cap4_d1[$];
  int stray = 0, ready_bad = 0, done4_cnt = 0;
  int kind = 0;
  int win[2][4];

  // Write/done monitor, sampled on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int b = 0; b < int'(BATCH); b++) begin
        if (wr_en[b] != '0) begin
          if (wr_en[b] != 2'b11) stray++;
          cap_bank.push_back(b);
          cap_addr.push_back(int'(wr_addr[b]));
          cap_d0.push_back(int'($signed(wr_data[b][0])));
          cap_d1.push_back(int'($signed(wr_data[b][1])));
          cap_cyc.push_back(cyc);
        end else if (wr_addr[b] != '0 || wr_data[b] != '0) begin
          stray++;
        end
        if (wr_en4[b] != '0) begin
          cap4_bank.push_back(b);
          cap4_addr.push_back(int'(wr_addr4[b]));
          cap4_d0.push_back(int'($signed(wr_data4[b][0])));
          cap4_d1.push_back(int'($signed(wr_data4[b][1])));
        end
      end
      if (wr_en[0] != '0 && wr_en[1] != '0) stray++;
      if (done) done_cyc.push_back(cyc);
      if (done4) done4_cnt++;
      if (busy ? (in_ready == (wr_en != '0)) : in_ready) ready_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int pix_val(int b, int g, int y, int x, int a);
    if (kind == 0) return x + 4 * y + 16 * g + a + 32 * b;
    return win[a][(y % 2) * 2 + (x % 2)];
  endfunction

  task automatic clear_caps();
    cap_bank.delete(); cap_addr.delete(); cap_d0.delete(); cap_d1.delete();
    cap_cyc.delete(); done_cyc.delete();
    stray = 0;
    ready_bad = 0;
  endtask

  task automatic pulse_start(input bit m);
    @(posedge clk); #1;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit bp, input bit poke);
    int b, rem, oy, g, r, t, idle;
    bit acc;
    for (int i = 0; i < n; i++) begin
      b = i / 8; rem = i % 8; oy = rem / 4; g = (rem % 4) / 2; r = rem % 2;
      if (bp) begin
        idle = int'($urandom_range(0, 2));
        for (int k = 0; k < idle; k++) begin
          in_valid = 1'b0;
          in_data  = {$urandom(), $urandom()};
          @(posedge clk); #1;
        end
      end
      for (int x = 0; x < int'(W); x++)
        for (int a = 0; a < int'(AF); a++)
          in_data[x][a] = 8'(pix_val(b, g, oy * 2 + r, x, a));
      in_valid = 1'b1;
      if (poke && i == 5) begin
        start = 1'b1;
        mode  = 1'b1;
      end
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        t++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL feed_timeout beat=%0d got in_ready=0 expected 1 within 50 cycles", i);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      @(posedge clk); #1;
      if (done_cyc.size() > 0) ok = 1'b1;
    end
  endtask

  task automatic run_job(input bit m, input bit bp, input bit poke, output bit ok);
    clear_caps();
    pulse_start(m);
    feed(16, bp, poke);
    wait_done(60, ok);
    mode = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = '1;
    start4 = 1'b0; mode4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready, |wr_en, |wr_addr, |wr_data} !== 6'b0)
      $display("FAIL reset_outputs got %b expected 000000", {busy, done, in_ready, |wr_en,
               |wr_addr, |wr_data});
    if ({busy, done, in_ready, |wr_en, |wr_addr, |wr_data} !== 6'b0) errors++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, in_ready, |wr_en} !== 3'b0) begin
      errors++;
      $display("FAIL idle_no_accept got busy,in_ready,wr=%b expected 000", {busy, in_ready, |wr_en});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic_max();
    bit ok;
    int eb, j, oy, g, ox, e0, f0, f1, lw, dc;
    kind = 0;
    run_job(1'b0, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done got no pulse expected one"); end
    checks++;
    if (cap_addr.size() != 16) begin
      errors++; $display("FAIL basic_count got %0d expected 16", cap_addr.size());
    end
    for (int k = 0; k < cap_addr.size() && k < 16; k++) begin
      eb = k / 8; j = k % 8; oy = j / 4; g = (j % 4) / 2; ox = j % 2;
      e0 = (2 * ox + 1) + 4 * (2 * oy + 1) + 16 * g + 32 * eb;
      checks++;
      if (cap_bank[k] !== eb || cap_addr[k] !== j || cap_d0[k] !== e0 || cap_d1[k] !== e0 + 1) begin
        errors++;
        $display("FAIL basic_write[%0d] got bank=%0d addr=%0d data=%0d,%0d expected %0d %0d %0d,%0d",
                 k, cap_bank[k], cap_addr[k], cap_d0[k], cap_d1[k], eb, j, e0, e0 + 1);
      end
    end
    f0 = (cap_d0.size() > 0) ? cap_d0[0] : -999;
    f1 = (cap_d0.size() > 1) ? cap_d0[1] : -999;
    checks++;
    if (f0 !== 5 || f1 !== 7) begin
      errors++; $display("FAIL basic_first_words got %0d,%0d expected 5,7", f0, f1);
    end
    lw = (cap_cyc.size() > 0) ? cap_cyc[$] : -100;
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    checks++;
    if (dc !== lw + 1 || done_cyc.size() != 1) begin
      errors++; $display("FAIL basic_done_timing got cycle %0d expected %0d", dc, lw + 1);
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL basic_other_banks got %0d stray expected 0", stray); end
  endtask

  task automatic test_signed_max();
    bit ok;
    kind = 1;
    win[0] = '{-128, -1, -5, -128};
    win[1] = '{3, 3, 3, 3};
    run_job(1'b0, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || cap_d0.size() != 16) begin
      errors++; $display("FAIL smax_count got %0d writes done=%0d expected 16 done=1", cap_d0.size(), ok);
    end
    for (int k = 0; k < cap_d0.size(); k += 5) begin
      checks++;
      if (cap_d0[k] !== -1 || cap_d1[k] !== 3) begin
        errors++;
        $display("FAIL smax_write[%0d] got %0d,%0d expected -1,3", k, cap_d0[k], cap_d1[k]);
      end
    end
  endtask

  task automatic test_avg_rounding();
    bit ok;
    kind = 1;
    win[0] = '{1, 2, 2, 2};
    win[1] = '{-1, -2, -2, -2};
    run_job(1'b1, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || cap_d0.size() != 16) begin
      errors++; $display("FAIL avg_a_count got %0d writes done=%0d expected 16 done=1", cap_d0.size(), ok);
    end
    for (int k = 0; k < cap_d0.size(); k += 5) begin
      checks++;
      if (cap_d0[k] !== 2 || cap_d1[k] !== -2) begin
        errors++; $display("FAIL avg_round[%0d] got %0d,%0d expected 2,-2", k, cap_d0[k], cap_d1[k]);
      end
    end
    win[0] = '{127, 127, 127, 127};
    win[1] = '{-128, -128, -128, -128};
    run_job(1'b1, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || cap_d0.size() != 16) begin
      errors++; $display("FAIL avg_b_count got %0d writes done=%0d expected 16 done=1", cap_d0.size(), ok);
    end
    for (int k = 0; k < cap_d0.size(); k += 5) begin
      checks++;
      if (cap_d0[k] !== 127 || cap_d1[k] !== -128) begin
        errors++; $display("FAIL avg_extreme[%0d] got %0d,%0d expected 127,-128", k, cap_d0[k], cap_d1[k]);
      end
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int eb, j, oy, g, ox, e0;
    kind = 0;
    run_job(1'b0, 1'b1, 1'b1, ok);
    checks++;
    if (!ok || cap_addr.size() != 16) begin
      errors++; $display("FAIL bp_count got %0d writes done=%0d expected 16 done=1", cap_addr.size(), ok);
    end
    for (int k = 0; k < cap_addr.size() && k < 16; k++) begin
      eb = k / 8; j = k % 8; oy = j / 4; g = (j % 4) / 2; ox = j % 2;
      e0 = (2 * ox + 1) + 4 * (2 * oy + 1) + 16 * g + 32 * eb;
      checks++;
      if (cap_bank[k] !== eb || cap_addr[k] !== j || cap_d0[k] !== e0 || cap_d1[k] !== e0 + 1) begin
        errors++;
        $display("FAIL bp_write[%0d] got bank=%0d addr=%0d data=%0d,%0d expected %0d %0d %0d,%0d",
                 k, cap_bank[k], cap_addr[k], cap_d0[k], cap_d1[k], eb, j, e0, e0 + 1);
      end
    end
    checks++;
    if (ready_bad !== 0) begin
      errors++; $display("FAIL bp_in_ready got %0d bad cycles expected 0", ready_bad);
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok, seen;
    int n_at_rst, f0;
    kind = 0;
    clear_caps();
    pulse_start(1'b0);
    feed(10, 1'b0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (wr_en[1] != '0) seen = 1'b1;
    end
    rst = 1'b1;
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_reach got no bank1 write expected one"); end
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready, |wr_en, |wr_addr, |wr_data} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_outputs got %b expected 000000", {busy, done, in_ready, |wr_en,
               |wr_addr, |wr_data});
    end
    rst = 1'b0;
    n_at_rst = cap_addr.size();
    repeat (20) @(negedge clk);
    checks++;
    if (cap_addr.size() != n_at_rst || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL midrst_quiet got %0d writes %0d done expected 0 and 0",
               cap_addr.size() - n_at_rst, done_cyc.size());
    end
    run_job(1'b0, 1'b0, 1'b0, ok);
    f0 = (cap_d0.size() > 0) ? cap_d0[0] : -999;
    checks++;
    if (!ok || cap_addr.size() != 16 || cap_bank[0] !== 0 || cap_addr[0] !== 0 || f0 !== 5) begin
      errors++;
      $display("FAIL midrst_restart got writes=%0d done=%0d first=%0d expected 16 1 5",
               cap_addr.size(), ok, f0);
    end
  endtask

  task automatic test_pool4_avg();
    int t;
    bit acc;
    cap4_bank.delete(); cap4_addr.delete(); cap4_d0.delete(); cap4_d1.delete();
    done4_cnt = 0;
    @(posedge clk); #1;
    mode4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    mode4 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      for (int x = 0; x < int'(W4); x++)
        for (int a = 0; a < int'(AF); a++) in_data4[x][a] = 8'd9;
      in_valid4 = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
        @(negedge clk); acc = in_ready4;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL p4_feed_timeout beat=%0d got in_ready=0 expected 1", i);
        break;
      end
    end
    in_valid4 = 1'b0;
    t = 0;
    while (done4_cnt == 0 && t < 60) begin @(posedge clk); #1; t++; end
    checks++;
    if (done4_cnt != 1 || cap4_addr.size() != 16) begin
      errors++;
      $display("FAIL p4_count got writes=%0d done=%0d expected 16 1", cap4_addr.size(), done4_cnt);
    end
    for (int k = 0; k < cap4_addr.size(); k++) begin
      checks++;
      if (cap4_bank[k] !== k / 8 || cap4_addr[k] !== k % 8 || cap4_d0[k] !== 9 || cap4_d1[k] !== 9) begin
        errors++;
        $display("FAIL p4_write[%0d] got bank=%0d addr=%0d data=%0d,%0d expected %0d %0d 9,9",
                 k, cap4_bank[k], cap4_addr[k], cap4_d0[k], cap4_d1[k], k / 8, k % 8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_max();
    test_signed_max();
    test_avg_rounding();
    test_back_pressure();
    test_reset_mid_job();
    test_pool4_avg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_pool_writer.md
Name: fc_pool_writer

Overview:
- Parametrised successor to the fixed 2x2 max-pool FC buffer writer.
- Consumes conv output rows (AF channels per beat) and pools them with a configurable square window POOL, stride POOL.
- Mode is runtime-selectable: signed max or rounded average.
- Writes pooled pixels into the BATCH-banked FC data buffer with per-batch byte enables. Accumulates in registers (no ping-pong RAMs) and back-pressures the input while emitting.

Parameters:
- AF, 3: channels packed per beat / per FC buffer word.
- BATCH, 9: number of FC buffer banks; one bank per batch image.
- DATA_WIDTH, 8: signed pixel width.
- C, 512: channel count; G = ceil(C/AF) channel groups.
- W_IN, 14: input row width; must be a multiple of POOL.
- H_IN, 14: input rows per channel group; must be a multiple of POOL.
- POOL, 2: window and stride; power of two in {2,4}. Elaboration assertion on every constraint above.
- ADDR_WIDTH, 32: FC buffer address width.
- Derived: W_OUT = W_IN/POOL, H_OUT = H_IN/POOL, SH = 2*log2(POOL), ACC_W = DATA_WIDTH+SH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a BATCH-image job; mode sampled here
- mode  in  1  0 = max, 1 = average
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after the last write of the last batch
- in_valid  in  1  input row beat valid
- in_ready  out  1  block accepts beat when in_valid && in_ready
- in_data  in  [W_IN][AF][DATA_WIDTH]  one input row, AF channels per pixel
- wr_en  out  [BATCH][AF]  byte enables, one bank per batch
- wr_addr  out  [BATCH][ADDR_WIDTH]  FC buffer word address
- wr_data  out  [BATCH][AF][DATA_WIDTH]  pooled pixel, AF channels

Behaviour:
- Reset: synchronous on rst, checked every clock edge. All outputs 0; state IDLE; all counters and accumulators 0. rst mid-job aborts without done, and no partial writes follow.
- Input order per batch: for oy in 0..H_OUT-1, for g in 0..G-1, POOL consecutive rows (oy*POOL+r, r = 0..POOL-1) of group g.
- IDLE: in_ready=0, busy=0. start -> ACCUM; latch mode; clear batch_cnt, oy, g, r.
- ACCUM: in_ready=1. On each accepted beat, per output column ox and channel a, fold the POOLxPOOL window portion of that row into acc[ox][a]:
  - max: signed compare; ties keep the older value.
  - avg: signed sum, sign-extended to ACC_W.
  - r==0 overwrites acc; r>0 folds into it.
  - r increments; on r==POOL-1 accept -> EMIT with ox=0.
- EMIT: in_ready=0. One write per cycle for W_OUT cycles, first write the cycle after the last row is accepted.
  - Bank batch_cnt: wr_en = all-ones; wr_addr = (oy*G+g)*W_OUT+ox, zero-extended; wr_data = result(acc[ox]).
  - Other banks: all-zero outputs. In IDLE/ACCUM/DONE, all write outputs are 0.
- avg result: (sum + 2^(SH-1)) >>> SH, arithmetic shift, rounds half toward +inf; cannot overflow DATA_WIDTH. max result is acc directly.
- After ox==W_OUT-1: g++; on g wrap, oy++; on oy wrap, batch_cnt++.
  - More work remains -> ACCUM.
  - Otherwise -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Writes per batch = H_OUT*G*W_OUT; input beats per batch = H_OUT*G*POOL.
- Ignored cases:
  - start while busy is ignored.
  - in_valid outside ACCUM is not accepted.
  - mode changes mid-job have no effect.
- in_valid may drop at any time in ACCUM: accumulator and counters hold, no writes.

Decomposition:
- Package fc_pool_pkg: pool_mode_e {POOL_MAX, POOL_AVG}; state enum {IDLE, ACCUM, EMIT, DONE}; ceil_div and clog2 helper functions.
- One sub-module, fc_pool_lane: per-(ox,a) accumulator holding fold/overwrite/max/sum logic and the result function. Generate W_OUT*AF instances.
- Top keeps the FSM, counters, address generation and bank demux.

Test Plan:
- Common setup: AF=2, BATCH=2, C=4 (G=2), W_IN=H_IN=4, POOL=2, mode=max.
- Basic max: row-major pixel value = x+4y per group. Expect 8 writes per batch, addr 0..7, bank0 then bank1. First word for ch0 is 5, then 7; done 1 cycle after write 16.
- Signed max: window {-128,-1,-5,-128} -> -1. Tie {3,3,3,3} -> 3.
- Avg rounding: windows {1,2,2,2} -> 2 (7+2>>2); {-1,-2,-2,-2} -> -2 (-7+2>>>2); {127 x4} -> 127; {-128 x4} -> -128.
- Back-pressure: in_valid toggled randomly -> identical writes to the basic max case. in_ready=0 exactly during the 2-cycle EMIT bursts.
- Reset mid-job: rst asserted during batch 1 EMIT -> all outputs 0 next cycle; no done. A new start runs cleanly from addr 0, bank 0.
- POOL=4, W_IN=H_IN=8, avg: constant input 9 -> every write 9; 4 writes per group per batch.
